ripple_add_sequencer: RTL and testbench
=======================================

Name: ripple_add_sequencer

Overview:
Multi-byte add/subtract sequencer that drives one shared 8-bit ripple_carry_adder instance, one byte per clock, LSB first.
- Latches two NBYTES-wide operands on a start handshake.
- Propagates the carry between byte slices through a registered carry.
- Assembles the wide result and reports carry-out and signed overflow.
- The adder itself stays combinational and external; this block only feeds it and captures its outputs.

Parameters:
NBYTES, 4, number of 8-bit slices per operation (width W = 8*NBYTES); legal range 2..16.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = A+B, 1 = A-B; latched with start
op_a  input  W  operand A; latched with start
op_b  input  W  operand B; latched with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE; result/flags valid from then until next accepted start
result  output  W  registered sum/difference
cy_out  output  1  final carry out of MSB slice (for sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow of the W-bit operation
adder_a  output  8  byte of A to adder
adder_b  output  8  byte of B (inverted when sub=1) to adder
adder_cin  output  1  carry into adder
adder_sum  input  8  adder sum
adder_cout  input  1  adder carry out

Behaviour:
- Asynchronous reset (rst_n=0) takes effect immediately and clears everything:
  - state=IDLE, byte index=0, carry reg=0, latched operands/sub=0.
  - result=0, cy_out=0, ovf=0, busy=0, done=0.
- Adder drive outputs:
  - adder_a, adder_b and adder_cin are 0 whenever state != RUN.
  - In RUN they are purely combinational from the latched operands, index and carry register.
- States and transitions:
  - IDLE: start=1 at an edge latches op_a, op_b, sub; sets idx=0, carry reg=sub; -> RUN. start=0: stay.
  - RUN: busy=1.
    - adder_a = A[8*idx+:8]; adder_b = B[8*idx+:8] XOR {8{sub}}; adder_cin = carry reg.
    - Each edge: result[8*idx+:8] <= adder_sum; carry reg <= adder_cout; idx <= idx+1.
    - On the edge with idx = NBYTES-1: cy_out <= adder_cout; ovf <= (a7 == b7') && (sum7 != a7), where b7' is the possibly inverted MSB of the MSB slice; -> DONE.
  - DONE: done=1 for exactly one cycle; -> IDLE unconditionally. start is ignored in DONE.
- Timing:
  - start accepted at edge E0; busy=1 after E0 through E(NBYTES).
  - done=1 for the cycle after E(NBYTES); back in IDLE after E(NBYTES+1).
  - Minimum start-to-start spacing is NBYTES+2 cycles.
- Operand and result rules:
  - start asserted while busy or done is dropped, with no queuing and no effect on the current operation.
  - op_a, op_b and sub may change freely after the accepting edge.
  - result bytes update progressively during RUN. Slices not yet written keep their previous values; consumers use result only when done=1 or later.
  - result, cy_out and ovf hold until the next operation overwrites them.
- Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
- Index counter width is clog2(NBYTES) bits, minimum 1. The index never wraps within an operation.

Test Plan:
1. NBYTES=4, start with A=0x000000AF, B=0x0000005A, sub=0 -> done 4 cycles after the accepting edge; result=0x00000109, cy_out=0, ovf=0; busy high exactly 4 cycles.
2. A=0xFFFFFFFF, B=0x00000001, sub=0 -> result=0x00000000, cy_out=1, ovf=0; carry ripples through all 4 slices (adder_cin=1 in slices 1..3).
3. A=0x00000100, B=0x00000001, sub=1 -> result=0x000000FF, cy_out=1, ovf=0; slice 0 sees adder_b=0xFE, adder_cin=1.
4. A=0x7FFFFFFF, B=0x00000001, sub=0 -> result=0x80000000, ovf=1, cy_out=0. Then A=0x80000000, B=0x00000001, sub=1 -> result=0x7FFFFFFF, ovf=1, cy_out=1.
5. Start with A=0x12345678, B=0x11111111. Pulse start with different operands 2 cycles later and again during the done cycle -> exactly one done pulse; result=0x23456789; the ignored starts have no effect.
6. Drive rst_n=0 mid-RUN (after 2 slices) -> busy, done, result, cy_out and ovf are 0 asynchronously with no done pulse. A new operation after rst_n=1 completes correctly.

Source files
------------

// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer: multi-byte add/subtract driving an external 8-bit ripple adder,
// one byte per clock, LSB first, with a registered inter-slice carry.
module ripple_add_sequencer #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES,
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cy_out,
    output logic         ovf,
    output logic [7:0]   adder_a,
    output logic [7:0]   adder_b,
    output logic         adder_cin,
    input  logic [7:0]   adder_sum,
    input  logic         adder_cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q, b_q;
    logic          sub_q, carry, last, run;

    assign run  = (state == RUN);
    assign last = (idx == IW'(NBYTES - 1));

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && start) ? RUN :
                    (run && last)            ? DONE :
                    (state == DONE)          ? IDLE : state;
        busy      = run;
        done      = (state == DONE);
        adder_a   = run ? a_q[{idx, 3'b000} +: 8] : 8'd0;
        adder_b   = run ? (b_q[{idx, 3'b000} +: 8] ^ {8{sub_q}}) : 8'd0;
        adder_cin = run & carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            result <= '0;
            cy_out <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                a_q   <= op_a;
                b_q   <= op_b;
                sub_q <= sub;
                idx   <= '0;
                carry <= sub;
            end else if (run) begin
                result[{idx, 3'b000} +: 8] <= adder_sum;
                carry <= adder_cout;
                if (last) begin
                    cy_out <= adder_cout;
                    // overflow: same-sign operands (after inversion) produced an opposite-sign sum
                    ovf    <= (adder_a[7] == adder_b[7]) && (adder_sum[7] != adder_a[7]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// tb_ripple_add_sequencer: randomized and directed checks of the sequencer against
// an arithmetic reference model, with the 8-bit adder modelled combinationally.
module tb_ripple_add_sequencer;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         busy, done, cy_out, ovf, adder_cin, adder_cout;
    logic [W-1:0] result;
    logic [7:0]   adder_a, adder_b, adder_sum;
    int           n_checks = 0, n_fail = 0;

    ripple_add_sequencer #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .cy_out(cy_out), .ovf(ovf),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'd0, adder_cin};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_drv"}, {adder_a, adder_b, adder_cin}, 0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
        logic [W-1:0] exp_r;
        logic         exp_c, exp_v;
        longint       sa;
        logic [63:0]  m, a64, b64, cin;
        int           cyc, busy_cnt;
        exp_r = s ? a - b : a + b;
        exp_c = s ? (a >= b) : (({32'd0, a} + {32'd0, b}) >= 64'h1_0000_0000);
        sa    = s ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
        exp_v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
        cyc = 0; busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (cyc < NB) begin
                m   = (64'd1 << (8 * cyc)) - 1;
                a64 = {32'd0, a};
                b64 = s ? {32'd0, ~b} : {32'd0, b};
                cin = ((a64 & m) + (b64 & m) + {63'd0, s}) >> (8 * cyc);
                chk({tag, "_adder_a"}, adder_a, a[8*cyc +: 8]);
                chk({tag, "_adder_b"}, adder_b, b[8*cyc +: 8] ^ {8{s}});
                chk({tag, "_adder_cin"}, adder_cin, cin[0]);
            end
            busy_cnt += int'(busy);
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, cyc, NB);
        chk({tag, "_busy_cycles"}, busy_cnt, NB);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_cy_out"}, cy_out, exp_c);
        chk({tag, "_ovf"}, ovf, exp_v);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_result_hold"}, result, exp_r);
    endtask

    initial begin
        int dones, bound;
        #12;
        chk("reset_result", result, 0);
        chk("reset_flags", {cy_out, ovf}, 0);
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        do_op(32'h000000AF, 32'h0000005A, 1'b0, "t1");
        chk_idle("t1_after");
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "t2");
        do_op(32'h00000100, 32'h00000001, 1'b1, "t3");
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, "t4a");
        do_op(32'h80000000, 32'h00000001, 1'b1, "t4b");
        do_op(32'h00000000, 32'h00000000, 1'b1, "sub_zero");
        do_op(32'h00000000, 32'h00000001, 1'b1, "borrow");

        // ignored starts: one during RUN, one during the done cycle
        @(negedge clk);
        op_a = 32'h12345678; op_b = 32'h11111111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dones = 0;
        @(negedge clk);
        op_a = 32'hDEADBEEF; op_b = 32'h01010101; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bound = 0;
        while (!done && bound < 20) begin
            bound++;
            @(negedge clk);
        end
        chk("t5_done_seen", done, 1);
        chk("t5_result", result, 32'h23456789);
        start = 1'b1;
        for (int i = 0; i < 2 * NB; i++) begin
            dones += int'(done);
            @(negedge clk);
            start = 1'b0;
        end
        chk("t5_done_count", dones, 1);
        chk("t5_not_restarted", busy, 0);
        chk("t5_result_hold", result, 32'h23456789);

        // asynchronous reset after two slices
        @(negedge clk);
        op_a = 32'hA5A5A5A5; op_b = 32'h5A5A5A5A; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_result", result, 0);
        chk("t6_flags", {cy_out, ovf}, 0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dones += int'(done);
        end
        chk("t6_no_done", dones, 0);
        rst_n = 1'b1;
        do_op(32'h12345678, 32'h87654321, 1'b0, "t6_after");

        for (int i = 0; i < 20; i++)
            do_op($urandom, $urandom, 1'($urandom), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
